// File: rtl/decode_queue.sv
// decode_queue: IF->ID decoupling queue with a registered MIPS32 control decoder.
// The queue holds up to DEPTH {pc, instr} pairs; the head entry is decoded
// combinationally and captured into a valid/ready output stage on pop.
// Optional feature macro: DECODE_TLB_EN (COP0 TLBR/TLBWI/TLBWR/TLBP decode as valid).
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [PC_W-1:0] if_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [PC_W-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic [3:0]      id_alu_op,
    output logic            id_src_b_imm,
    output logic            id_ext_sign,
    output logic [1:0]      id_dst_sel,
    output logic            id_reg_wr,
    output logic            id_mem_rd,
    output logic            id_mem_wr,
    output logic [1:0]      id_mem_size,
    output logic            id_mem_uns,
    output logic [2:0]      id_exc
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [PC_W-1:0] pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]     count_reg;

    logic            push, pop, head_valid;
    logic [31:0]     head_instr;
    logic [PC_W-1:0] head_pc;

    // Readiness is purely a function of occupancy, so a full queue never
    // accepts even when the head leaves in the same cycle.
    assign if_ready   = (count_reg < FULL_COUNT);
    assign head_valid = (count_reg != '0);
    assign push       = if_valid && if_ready;
    assign pop        = head_valid && (!id_valid || id_ready);
    assign head_instr = instr_mem[rd_ptr_reg];
    assign head_pc    = pc_mem[rd_ptr_reg];

    // Storage write; entries need no reset because occupancy gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_reg] <= if_instr;
            pc_mem[wr_ptr_reg]    <= if_pc;
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (pop && !push) count_reg <= count_reg - 1'b1;
        end
    end

    logic [5:0] opcode, funct;
    logic [4:0] rs, rt, shamt;
    assign opcode = head_instr[31:26];
    assign rs     = head_instr[25:21];
    assign rt     = head_instr[20:16];
    assign shamt  = head_instr[10:6];
    assign funct  = head_instr[5:0];

    logic [3:0] d_alu_op;
    logic       d_src_b_imm, d_ext_sign, d_reg_wr, d_mem_rd, d_mem_wr, d_mem_uns, ri;
    logic [1:0] d_dst_sel, d_mem_size;
    logic [2:0] d_exc;

    // Decode the head entry into the control bundle; anything unrecognised
    // collapses to a bare reserved-instruction exception.
    always_comb begin
        d_alu_op = 4'd0; d_src_b_imm = 1'b0; d_ext_sign = 1'b0; d_dst_sel = 2'd0;
        d_reg_wr = 1'b0; d_mem_rd = 1'b0; d_mem_wr = 1'b0; d_mem_size = 2'd0;
        d_mem_uns = 1'b0; d_exc = 3'b000; ri = 1'b0;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20: begin d_alu_op = 4'd1;  d_reg_wr = 1'b1; end
                    6'h21: begin d_alu_op = 4'd2;  d_reg_wr = 1'b1; end
                    6'h22: begin d_alu_op = 4'd3;  d_reg_wr = 1'b1; end
                    6'h23: begin d_alu_op = 4'd4;  d_reg_wr = 1'b1; end
                    6'h2A: begin d_alu_op = 4'd5;  d_reg_wr = 1'b1; end
                    6'h2B: begin d_alu_op = 4'd6;  d_reg_wr = 1'b1; end
                    6'h24: begin d_alu_op = 4'd7;  d_reg_wr = 1'b1; end
                    6'h25: begin d_alu_op = 4'd8;  d_reg_wr = 1'b1; end
                    6'h26: begin d_alu_op = 4'd9;  d_reg_wr = 1'b1; end
                    6'h27: begin d_alu_op = 4'd10; d_reg_wr = 1'b1; end
                    6'h00: begin d_alu_op = 4'd11; d_reg_wr = 1'b1; ri = (rs != 5'd0); end
                    6'h02: begin d_alu_op = 4'd12; d_reg_wr = 1'b1; ri = (rs != 5'd0); end
                    6'h03: begin d_alu_op = 4'd13; d_reg_wr = 1'b1; ri = (rs != 5'd0); end
                    6'h04: begin d_alu_op = 4'd11; d_reg_wr = 1'b1; ri = (shamt != 5'd0); end
                    6'h06: begin d_alu_op = 4'd12; d_reg_wr = 1'b1; ri = (shamt != 5'd0); end
                    6'h07: begin d_alu_op = 4'd13; d_reg_wr = 1'b1; ri = (shamt != 5'd0); end
                    6'h08: begin end                                 // JR
                    6'h09: d_reg_wr = 1'b1;                          // JALR -> rd
                    6'h0C: d_exc = 3'b010;                           // SYSCALL
                    6'h0D: d_exc = 3'b100;                           // BREAK
                    6'h10, 6'h12: d_reg_wr = 1'b1;                   // MFHI/MFLO
                    default: ri = 1'b1;
                endcase
            end
            6'h01: begin
                case (rt)
                    5'h00, 5'h01: begin end                          // BLTZ/BGEZ
                    5'h10, 5'h11: begin d_dst_sel = 2'd2; d_reg_wr = 1'b1; end
                    default: ri = 1'b1;
                endcase
            end
            6'h02, 6'h04, 6'h05, 6'h06, 6'h07: begin end            // J, branches
            6'h03: begin d_dst_sel = 2'd2; d_reg_wr = 1'b1; end      // JAL
            6'h08, 6'h09, 6'h0A, 6'h0B: begin
                d_alu_op    = (opcode == 6'h08) ? 4'd1 : (opcode == 6'h09) ? 4'd2 :
                              (opcode == 6'h0A) ? 4'd5 : 4'd6;
                d_src_b_imm = 1'b1; d_ext_sign = 1'b1; d_dst_sel = 2'd1; d_reg_wr = 1'b1;
            end
            6'h0C, 6'h0D, 6'h0E: begin
                d_alu_op    = (opcode == 6'h0C) ? 4'd7 : (opcode == 6'h0D) ? 4'd8 : 4'd9;
                d_src_b_imm = 1'b1; d_dst_sel = 2'd1; d_reg_wr = 1'b1;
            end
            6'h0F: begin d_alu_op = 4'd14; d_src_b_imm = 1'b1; d_dst_sel = 2'd1; d_reg_wr = 1'b1; end
            6'h10: begin
                if (rs == 5'h00) begin d_dst_sel = 2'd1; d_reg_wr = 1'b1; end  // MFC0
                else if (rs == 5'h04) begin end                              // MTC0
                else if (rs[4]) begin
                    case (funct)
                        6'h18: begin end                                     // ERET
`ifdef DECODE_TLB_EN
                        6'h01, 6'h02, 6'h06, 6'h08: begin end                // TLB ops
`else
                        6'h01, 6'h02, 6'h06, 6'h08: ri = 1'b1;
`endif
                        default: ri = 1'b1;
                    endcase
                end else ri = 1'b1;
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                d_mem_rd = 1'b1; d_alu_op = 4'd2; d_src_b_imm = 1'b1; d_ext_sign = 1'b1;
                d_dst_sel = 2'd1; d_reg_wr = 1'b1;
                d_mem_size = (opcode[1:0] == 2'b11) ? 2'd2 : {1'b0, opcode[0]};
                d_mem_uns  = opcode[2];
            end
            6'h28, 6'h29, 6'h2B: begin
                d_mem_wr = 1'b1; d_alu_op = 4'd2; d_src_b_imm = 1'b1; d_ext_sign = 1'b1;
                d_mem_size = (opcode[1:0] == 2'b11) ? 2'd2 : {1'b0, opcode[0]};
            end
            default: ri = 1'b1;
        endcase
        if (ri) begin
            d_alu_op = 4'd0; d_src_b_imm = 1'b0; d_ext_sign = 1'b0; d_dst_sel = 2'd0;
            d_reg_wr = 1'b0; d_mem_rd = 1'b0; d_mem_wr = 1'b0; d_mem_size = 2'd0;
            d_mem_uns = 1'b0; d_exc = 3'b001;
        end
    end

    // Output stage: load on pop, hold while stalled, drop valid once consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid <= 1'b0; id_pc <= '0; id_instr <= '0; id_alu_op <= '0;
            id_src_b_imm <= 1'b0; id_ext_sign <= 1'b0; id_dst_sel <= '0; id_reg_wr <= 1'b0;
            id_mem_rd <= 1'b0; id_mem_wr <= 1'b0; id_mem_size <= '0; id_mem_uns <= 1'b0;
            id_exc <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (pop) begin
            id_valid <= 1'b1; id_pc <= head_pc; id_instr <= head_instr; id_alu_op <= d_alu_op;
            id_src_b_imm <= d_src_b_imm; id_ext_sign <= d_ext_sign; id_dst_sel <= d_dst_sel;
            id_reg_wr <= d_reg_wr; id_mem_rd <= d_mem_rd; id_mem_wr <= d_mem_wr;
            id_mem_size <= d_mem_size; id_mem_uns <= d_mem_uns; id_exc <= d_exc;
        end else if (id_ready) begin
            id_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: directed scenarios plus randomized traffic for decode_queue,
// checked against a queue-based behavioural model and a mnemonic-level decoder.
module tb_decode_queue;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, if_valid = 1'b0, id_ready = 1'b0;
    logic [31:0] if_instr = '0;
    logic [PC_W-1:0] if_pc = '0;
    logic if_ready, id_valid, id_src_b_imm, id_ext_sign, id_reg_wr, id_mem_rd, id_mem_wr, id_mem_uns;
    logic [PC_W-1:0] id_pc;
    logic [31:0] id_instr;
    logic [3:0] id_alu_op;
    logic [1:0] id_dst_sel, id_mem_size;
    logic [2:0] id_exc;

    decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .if_valid(if_valid), .if_ready(if_ready),
        .if_instr(if_instr), .if_pc(if_pc), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_instr(id_instr), .id_alu_op(id_alu_op), .id_src_b_imm(id_src_b_imm),
        .id_ext_sign(id_ext_sign), .id_dst_sel(id_dst_sel), .id_reg_wr(id_reg_wr),
        .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .id_mem_size(id_mem_size),
        .id_mem_uns(id_mem_uns), .id_exc(id_exc)
    );

    always #5 clk = ~clk;

    wire [80:0] obs = {id_pc, id_instr, id_alu_op, id_src_b_imm, id_ext_sign, id_dst_sel,
                       id_reg_wr, id_mem_rd, id_mem_wr, id_mem_size, id_mem_uns, id_exc};

    int n_vec = 0, n_err = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference decoder: name the instruction first, then attach its properties.
    typedef enum {I_BAD, I_R, I_SHIFT, I_JR, I_JALR, I_SYS, I_BRK, I_MFHL, I_BR, I_LINK,
                  I_IMMS, I_IMMZ, I_LUI, I_MFC0, I_NOWR, I_LOAD, I_STORE} kind_t;

    function automatic logic [16:0] ref_ctrl(input logic [31:0] w);
        kind_t k;
        logic [3:0] alu;
        logic [1:0] sz;
        logic [5:0] op, fn;
        logic [4:0] rs, rt, sa;
        op = w[31:26]; fn = w[5:0]; rs = w[25:21]; rt = w[20:16]; sa = w[10:6];
        k = I_BAD; alu = 4'd0; sz = 2'd0;
        if (op == 6'h00) begin
            case (fn)
                6'h20: begin k = I_R; alu = 1; end   6'h21: begin k = I_R; alu = 2; end
                6'h22: begin k = I_R; alu = 3; end   6'h23: begin k = I_R; alu = 4; end
                6'h2A: begin k = I_R; alu = 5; end   6'h2B: begin k = I_R; alu = 6; end
                6'h24: begin k = I_R; alu = 7; end   6'h25: begin k = I_R; alu = 8; end
                6'h26: begin k = I_R; alu = 9; end   6'h27: begin k = I_R; alu = 10; end
                6'h00: if (rs == 0) begin k = I_R; alu = 11; end
                6'h02: if (rs == 0) begin k = I_R; alu = 12; end
                6'h03: if (rs == 0) begin k = I_R; alu = 13; end
                6'h04: if (sa == 0) begin k = I_R; alu = 11; end
                6'h06: if (sa == 0) begin k = I_R; alu = 12; end
                6'h07: if (sa == 0) begin k = I_R; alu = 13; end
                6'h08: k = I_JR;  6'h09: k = I_JALR;
                6'h0C: k = I_SYS; 6'h0D: k = I_BRK;
                6'h10, 6'h12: k = I_MFHL;
                default: k = I_BAD;
            endcase
        end else if (op == 6'h01) begin
            if (rt == 5'h00 || rt == 5'h01) k = I_BR;
            else if (rt == 5'h10 || rt == 5'h11) k = I_LINK;
        end else if (op == 6'h02 || (op >= 6'h04 && op <= 6'h07)) k = I_BR;
        else if (op == 6'h03) k = I_LINK;
        else if (op == 6'h08) begin k = I_IMMS; alu = 1; end
        else if (op == 6'h09) begin k = I_IMMS; alu = 2; end
        else if (op == 6'h0A) begin k = I_IMMS; alu = 5; end
        else if (op == 6'h0B) begin k = I_IMMS; alu = 6; end
        else if (op == 6'h0C) begin k = I_IMMZ; alu = 7; end
        else if (op == 6'h0D) begin k = I_IMMZ; alu = 8; end
        else if (op == 6'h0E) begin k = I_IMMZ; alu = 9; end
        else if (op == 6'h0F) k = I_LUI;
        else if (op == 6'h10) begin
            if (rs == 5'h00) k = I_MFC0;
            else if (rs == 5'h04) k = I_NOWR;
            else if (w[25] && fn == 6'h18) k = I_NOWR;
`ifdef DECODE_TLB_EN
            else if (w[25] && (fn == 6'h01 || fn == 6'h02 || fn == 6'h06 || fn == 6'h08)) k = I_NOWR;
`endif
        end
        else if (op == 6'h20) begin k = I_LOAD; sz = 0; end
        else if (op == 6'h21) begin k = I_LOAD; sz = 1; end
        else if (op == 6'h23) begin k = I_LOAD; sz = 2; end
        else if (op == 6'h24) begin k = I_LOAD; sz = 0; end
        else if (op == 6'h25) begin k = I_LOAD; sz = 1; end
        else if (op == 6'h28) begin k = I_STORE; sz = 0; end
        else if (op == 6'h29) begin k = I_STORE; sz = 1; end
        else if (op == 6'h2B) begin k = I_STORE; sz = 2; end
        // {alu, src_b_imm, ext_sign, dst_sel, reg_wr, mem_rd, mem_wr, mem_size, mem_uns, exc}
        case (k)
            I_R, I_JALR, I_MFHL: return {alu, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000};
            I_JR, I_BR, I_NOWR:  return 17'd0;
            I_SYS:   return {14'd0, 3'b010};
            I_BRK:   return {14'd0, 3'b100};
            I_LINK:  return {4'd0, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000};
            I_IMMS:  return {alu, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000};
            I_IMMZ:  return {alu, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000};
            I_LUI:   return {4'd14, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000};
            I_MFC0:  return {4'd0, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 3'b000};
            I_LOAD:  return {4'd2, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 1'b0, sz, (op == 6'h24 || op == 6'h25), 3'b000};
            I_STORE: return {4'd2, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, sz, 1'b0, 3'b000};
            default: return {14'd0, 3'b001};
        endcase
    endfunction

    // Model state: FIFO contents plus the expected output-stage bundle.
    logic [63:0] mq[$];
    logic        mv = 1'b0;
    logic [80:0] mb = '0;

    // One cycle: check outputs at the negedge, drive inputs, advance model, clock.
    task automatic step(input logic fl, input logic iv, input logic [31:0] ins, input logic rdy);
        logic push, pop;
        logic [63:0] e;
        chk("if_ready", if_ready, mq.size() < DEPTH);
        chk("id_valid", id_valid, mv);
        if (mv) chk("bundle", obs, mb);
        flush = fl; if_valid = iv; if_instr = ins; if_pc = pc_ctr; id_ready = rdy;
        if (fl) begin
            mq.delete(); mv = 1'b0;
        end else begin
            push = iv && (mq.size() < DEPTH);
            pop  = (mq.size() > 0) && (!mv || rdy);
            if (pop) begin
                e = mq.pop_front();
                mb = {e, ref_ctrl(e[31:0])}; mv = 1'b1;
            end else if (rdy) mv = 1'b0;
            if (push) mq.push_back({pc_ctr, ins});
        end
        if (iv) pc_ctr = pc_ctr + 4;
        @(posedge clk); @(negedge clk);
    endtask

    // Push one instruction then idle one cycle with id_ready high.
    task automatic one(input logic [31:0] ins);
        step(1'b0, 1'b1, ins, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        logic [5:0] ops [20] = '{6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h07, 6'h08, 6'h09, 6'h0B,
                                 6'h0C, 6'h0E, 6'h0F, 6'h10, 6'h20, 6'h21, 6'h23, 6'h25, 6'h28, 6'h2B};
        logic [5:0] fns [12] = '{6'h00, 6'h03, 6'h04, 6'h07, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h10, 6'h21, 6'h2A, 6'h27};
        logic [5:0] cfn [5] = '{6'h18, 6'h01, 6'h02, 6'h06, 6'h08};
        logic [4:0] rts [4] = '{5'h00, 5'h01, 5'h10, 5'h11};
        logic [4:0] c0r [3] = '{5'h00, 5'h04, 5'h10};
        w = $urandom;
        if ($urandom_range(0, 9) < 7) begin
            w[31:26] = ops[$urandom_range(0, 19)];
            if (w[31:26] == 6'h00 && $urandom_range(0, 1) == 1) begin
                w[5:0] = fns[$urandom_range(0, 11)];
                if ($urandom_range(0, 1) == 1) w[25:21] = 5'd0;
                if ($urandom_range(0, 1) == 1) w[10:6] = 5'd0;
            end
            if (w[31:26] == 6'h01 && $urandom_range(0, 1) == 1) w[20:16] = rts[$urandom_range(0, 3)];
            if (w[31:26] == 6'h10 && $urandom_range(0, 3) != 0) begin
                w[25:21] = c0r[$urandom_range(0, 2)];
                w[5:0] = cfn[$urandom_range(0, 4)];
            end
        end
        return w;
    endfunction

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_out", {id_valid, obs}, 82'd0);
        chk("rst_if_ready", if_ready, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // 1: ADDU reaches the output stage after the second edge
        one(32'h0085_1021);
        chk("t1_valid", id_valid, 1'b1);
        chk("t1_ctrl", {id_alu_op, id_dst_sel, id_reg_wr, id_exc}, {4'd2, 2'd0, 1'b1, 3'b000});

        // 2: LW
        one(32'h8C82_0004);
        chk("t2_ctrl", {id_mem_rd, id_mem_size, id_mem_uns, id_src_b_imm, id_ext_sign, id_dst_sel},
            {1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 2'd1});

        // 3: stall output, six back-to-back pushes; full after five accepted
        step(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 32'h2402_0000 + i, 1'b0);
        chk("t3_full", if_ready, 1'b0);

        // 4: flush a full queue while fetch is still presenting
        step(1'b1, 1'b1, 32'h2403_0077, 1'b0);
        chk("t4_valid", id_valid, 1'b0);
        chk("t4_ready", if_ready, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h3404_0100 + i, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b1);

        // 5: reserved opcode, SLL with rs!=0, SYSCALL
        one(32'hFC00_0000);
        chk("t5_resv", {id_exc, id_alu_op, id_reg_wr}, {3'b001, 4'd0, 1'b0});
        one(32'h0020_0000);
        chk("t5_sll", id_exc, 3'b001);
        one(32'h0000_000C);
        chk("t5_sys", id_exc, 3'b010);

        // 6: TLBWI, then asynchronous reset mid-stream
        one(32'h4200_0002);
`ifdef DECODE_TLB_EN
        chk("t6_tlbwi", id_exc, 3'b000);
`else
        chk("t6_tlbwi", id_exc, 3'b001);
`endif
        step(1'b0, 1'b1, 32'h0085_1021, 1'b0);
        step(1'b0, 1'b1, 32'h8C82_0004, 1'b0);
        #2 rst = 1'b1;
        #1 chk("t6_rst_out", {id_valid, obs}, 82'd0);
        chk("t6_rst_ready", if_ready, 1'b1);
        mq.delete(); mv = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7, gen_instr(),
                 $urandom_range(0, 9) < 6);
        for (int c = 0; c < 8; c++) step(1'b0, 1'b0, 32'h0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
